pipe_stage_reg: RTL

Parametrised inter-stage pipeline register for the five-stage MIPS core, generalising the EX/MEM latch so one module serves any stage boundary. It carries the register-file write triple, the HI/LO write triple and a valid bit. It holds multi-cycle scratch state (accumulator and step counter for madd/msub/div) across stalls. It adds a flush input and a saturating stall-cycle counter that the original latch lacks.

---
 rtl/pipe_stage_reg.sv | 119 +++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline latch: carries the register-file and HI/LO write
// triples plus a valid bit, holds multi-cycle scratch state, and counts stalls.
module pipe_stage_reg #(
    parameter int STAGE   = 3,
    parameter int STALL_W = 6,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int TMP_W   = 64,
    parameter int CNT_W   = 2,
    parameter int SC_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [STALL_W-1:0] stall,
    input  logic               in_valid,
    input  logic [ADDR_W-1:0]  in_wd,
    input  logic               in_wreg,
    input  logic [DATA_W-1:0]  in_wdata,
    input  logic [DATA_W-1:0]  in_hi,
    input  logic [DATA_W-1:0]  in_lo,
    input  logic               in_whilo,
    input  logic [TMP_W-1:0]   tmp_i,
    input  logic [CNT_W-1:0]   cnt_i,
    output logic               out_valid,
    output logic [ADDR_W-1:0]  out_wd,
    output logic               out_wreg,
    output logic [DATA_W-1:0]  out_wdata,
    output logic [DATA_W-1:0]  out_hi,
    output logic [DATA_W-1:0]  out_lo,
    output logic               out_whilo,
    output logic [TMP_W-1:0]   tmp_o,
    output logic [CNT_W-1:0]   cnt_o,
    output logic [SC_W-1:0]    stall_cycles
);

    generate
        if (STAGE < 0 || STAGE > STALL_W - 2) begin : g_badStage
            $error("pipe_stage_reg: STAGE must lie in 0..STALL_W-2");
        end
    endgenerate

    logic               r_valid;
    logic [ADDR_W-1:0]  r_wd;
    logic               r_wreg;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_hi;
    logic [DATA_W-1:0]  r_lo;
    logic               r_whilo;
    logic [TMP_W-1:0]   r_tmp;
    logic [CNT_W-1:0]   r_cnt;
    logic [SC_W-1:0]    r_sc;

    logic               w_s;
    logic               w_d;
    logic [SC_W-1:0]    w_scNext;
    logic               w_unusedStall;

    assign w_s = stall[STAGE];
    assign w_d = stall[STAGE+1];
    // Only this stage and its downstream neighbour matter; the rest are folded away.
    assign w_unusedStall = ^stall;

    assign w_scNext = (r_sc == {SC_W{1'b1}}) ? r_sc : r_sc + SC_W'(1);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid <= 1'b0;
            r_wd    <= '0;
            r_wreg  <= 1'b0;
            r_wdata <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_whilo <= 1'b0;
            r_tmp   <= '0;
            r_cnt   <= '0;
            r_sc    <= '0;
        end else if (!w_s) begin
            r_valid <= in_valid;
            r_wd    <= in_wd;
            r_wreg  <= in_wreg;
            r_wdata <= in_wdata;
            r_hi    <= in_hi;
            r_lo    <= in_lo;
            r_whilo <= in_whilo;
            r_tmp   <= '0;
            r_cnt   <= '0;
            r_sc    <= '0;
        end else if (!w_d) begin
            // Bubble downstream while the multi-cycle unit keeps iterating.
            r_valid <= 1'b0;
            r_wd    <= '0;
            r_wreg  <= 1'b0;
            r_wdata <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_whilo <= 1'b0;
            r_tmp   <= tmp_i;
            r_cnt   <= cnt_i;
            r_sc    <= w_scNext;
        end else begin
            r_tmp   <= tmp_i;
            r_cnt   <= cnt_i;
            r_sc    <= w_scNext;
        end
    end

    assign out_valid    = r_valid;
    assign out_wd       = r_wd;
    assign out_wreg     = r_wreg;
    assign out_wdata    = r_wdata;
    assign out_hi       = r_hi;
    assign out_lo       = r_lo;
    assign out_whilo    = r_whilo;
    assign tmp_o        = r_tmp;
    assign cnt_o        = r_cnt;
    assign stall_cycles = r_sc;

endmodule
